tnoc_output_port_arbiter: RTL and testbench
===========================================

// Module: tnoc_output_port_arbiter
// PURPOSE
//  Owner of one router output port. Takes the per-VC packet requests that the
//  route selectors of all input ports raise toward this port and returns grants.
//  Lock: once granted, a requester owns its VC at this port until its tail flit.
//  Per flit, picks one locked VC to drive the port.
//  One instance per available output port; grants feed the port's VC merger.
// PARAMETERS
//  CHANNELS        2    virtual channels per port
//  REQUESTERS      5    input ports competing for this output port
//  WATCHDOG_CYCLES 1024 idle-lock limit, used only with the watchdog build
// PORTS
//  clk                  in   1                     clock, all logic on rising edge
//  rst                  in   1                     synchronous reset, active-high
//  i_request            in   CHANNELS*REQUESTERS   flit valid toward this port; idx c*REQUESTERS+r
//  i_free               in   CHANNELS*REQUESTERS   flit accepted this cycle (valid&&ready)
//  i_start_of_packet    in   CHANNELS*REQUESTERS   head flit valid
//  i_end_of_packet      in   CHANNELS*REQUESTERS   tail flit accepted
//  i_vc_available       in   CHANNELS              downstream VC can take a flit
//  o_grant              out  CHANNELS*REQUESTERS   registered packet ownership, one-hot per VC
//  o_vc_grant           out  CHANNELS              one-hot VC allowed to drive the port this cycle
//  o_watchdog_error     out  1                     sticky; present only with the watchdog build
// BEHAVIOUR
//  Per-VC FSM with two states: IDLE and LOCKED.
//  - IDLE -> LOCKED when any r has i_request && i_start_of_packet.
//    Winner chosen round-robin: search starts at (last_winner+1) mod REQUESTERS.
//    last_winner resets to REQUESTERS-1, so requester 0 wins first.
//    o_grant bit for the winner rises the next cycle. Request-to-grant latency is 1 cycle.
//  - A request without start_of_packet never wins.
//  - LOCKED -> IDLE on i_end_of_packet of the owner.
//    o_grant for that owner clears the next cycle. No other requester is granted in that cycle.
//    A new winner is picked from the following cycle. Minimum packet-to-packet gap is 1 cycle.
//  - LOCKED ignores requests from non-owners. Grant is held through owner
//    bubbles (i_request low) with no limit in the default build.
//  - End and new head in the same cycle from the same requester: the end takes
//    precedence. The requester may win again on a later cycle.
//  VC arbitration:
//  - Candidate VC: it is LOCKED, the owner's i_request is high, and i_vc_available[c] is high.
//  - o_vc_grant is combinational, fixed priority, lowest c wins, all-zero if there is no candidate.
//  - Flit-level interleaving of VCs is legal.
//  Boundaries:
//  - CHANNELS=1: o_vc_grant equals candidate[0].
//  - REQUESTERS=1: round-robin degenerates to the single requester.
//  - i_end_of_packet on a non-owner is ignored.
//  - A single-flit packet (head and tail together) is legal. The block must not
//    lock on it before a grant exists, since end_of_packet requires ready and
//    ready requires grant.
//  Reset: rst mid-packet forces all VCs to IDLE the next edge.
//  - Reset values: o_grant=0, last_winner=REQUESTERS-1, o_watchdog_error=0.
//  - o_vc_grant follows the reset state, so it is 0.
// CONFIGURATION
//  TNOC_PORT_ARBITER_WATCHDOG_EN defined:
//  - One counter per VC.
//  - The counter increments while LOCKED and the owner has no i_free.
//  - It clears on i_free or on IDLE.
//  - When it reaches WATCHDOG_CYCLES-1, o_watchdog_error sets and stays set until rst.
//  - The lock itself is not broken.
//  Not defined: no counters; o_watchdog_error absent.
// STRUCTURE
//  tnoc_pkg: add e_arbiter_state {ARB_IDLE, ARB_LOCKED}.
//  tnoc_pkg: add function round_robin_select(req, last) returning a one-hot vector.
//  Sub-module tnoc_vc_lock_arbiter: one VC's FSM, round-robin pointer and watchdog.
//  It is instantiated CHANNELS times in a generate loop.
//  VC fixed-priority selection stays in the top module.
// TESTING
//  T1 CHANNELS=2, R=5:
//   - Stimulus: r2 on VC0 raises req+sop at cycle 0.
//   - Required: o_grant[2]=1 at cycle 1; o_vc_grant=2'b01 while r2 requests.
//  T2 fairness:
//   - Stimulus: r0, r1, r4 all hold head requests on VC0. Each packet is 3 flits.
//   - Required: grant order r0, r1, r4, r0. There is a 1-cycle gap between packets.
//  T3 VC interleave:
//   - Stimulus: VC0 and VC1 both locked. i_vc_available=2'b10 for 2 cycles, then 2'b11.
//   - Required: o_vc_grant=2'b10, 2'b10, then 2'b01.
//  T4 owner bubble:
//   - Stimulus: the owner drops i_request for 4 cycles mid-packet while r3 requests.
//   - Required: grant stays with the owner; o_vc_grant=0 during the bubble.
//  T5 reset:
//   - Stimulus: assert rst while VC1 is LOCKED mid-packet.
//   - Required: o_grant=0 the next cycle; the next head from r0 is granted first.
//  T6 watchdog build, WATCHDOG_CYCLES=8:
//   - Stimulus: the owner never gets i_free.
//   - Required: o_watchdog_error rises at cycle 8 after lock and stays high until rst.

Source files
------------

// File: rtl/tnoc_output_port_arbiter_pkg.sv
// Shared types and the round-robin helper for the output-port arbiter.
// Pure declarations: no state, no latency, no flow control of its own.
package tnoc_output_port_arbiter_pkg;

   localparam int RR_MAX   = 16;
   localparam int RR_IDX_W = 4;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } e_arbiter_state;

   // One-hot pick among the low n bits of req, searching from (last+1) mod n upward.
   function automatic logic [RR_MAX-1:0] round_robin_select(
      input logic [RR_MAX-1:0]   req,
      input logic [RR_IDX_W-1:0] last,
      input int                  n
   );
      logic [RR_MAX-1:0] sel;
      logic              found;
      int                idx;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= RR_MAX; i++) begin
         if (i <= n) begin
            idx = (int'(last) + i) % n;
            if (!found && req[idx[RR_IDX_W-1:0]]) begin
               sel[idx[RR_IDX_W-1:0]] = 1'b1;
               found = 1'b1;
            end
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/tnoc_output_port_arbiter_if.sv
// Request/grant bundle between the input ports' route selectors and one output-port arbiter.
// Build option TNOC_PORT_ARBITER_WATCHDOG_EN adds the sticky watchdog flag.
interface tnoc_output_port_arbiter_if #(
   parameter int CHANNELS   = 2,
   parameter int REQUESTERS = 5
);
   logic [CHANNELS*REQUESTERS-1:0] i_request;
   logic [CHANNELS*REQUESTERS-1:0] i_free;
   logic [CHANNELS*REQUESTERS-1:0] i_start_of_packet;
   logic [CHANNELS*REQUESTERS-1:0] i_end_of_packet;
   logic [CHANNELS-1:0]            i_vc_available;
   logic [CHANNELS*REQUESTERS-1:0] o_grant;
   logic [CHANNELS-1:0]            o_vc_grant;
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
   logic                           o_watchdog_error;
`endif

   modport master (
      output i_request,
      output i_free,
      output i_start_of_packet,
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
      input  o_watchdog_error,
`endif
      output i_end_of_packet,
      output i_vc_available,
      input  o_grant,
      input  o_vc_grant
   );

   modport slave (
      input  i_request,
      input  i_free,
      input  i_start_of_packet,
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
      output o_watchdog_error,
`endif
      input  i_end_of_packet,
      input  i_vc_available,
      output o_grant,
      output o_vc_grant
   );
endinterface

// File: rtl/tnoc_vc_lock_arbiter.sv
// One VC's packet lock: round-robin winner among heads, held until the owner's tail; grant 1 cycle after head.
// Never stalls requesters; non-owners simply wait. Build option TNOC_PORT_ARBITER_WATCHDOG_EN adds the idle-lock watchdog.
module tnoc_vc_lock_arbiter
   import tnoc_output_port_arbiter_pkg::*;
#(
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
   parameter int WATCHDOG_CYCLES = 1024,
`endif
   parameter int REQUESTERS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REQUESTERS-1:0] i_request,
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
   input  logic [REQUESTERS-1:0] i_free,
   output logic                  o_watchdog_error,
`endif
   input  logic [REQUESTERS-1:0] i_start_of_packet,
   input  logic [REQUESTERS-1:0] i_end_of_packet,
   output logic [REQUESTERS-1:0] o_grant,
   output logic                  o_owner_request
);

   e_arbiter_state        r_state;
   e_arbiter_state        w_state_next;
   logic [REQUESTERS-1:0] r_grant;
   logic [RR_IDX_W-1:0]   r_last;
   logic [REQUESTERS-1:0] w_head;
   logic [REQUESTERS-1:0] w_winner;
   logic [RR_IDX_W-1:0]   w_winner_idx;
   logic [RR_MAX-1:0]     w_rr;
   logic                  w_owner_end;

   assign w_head      = i_request & i_start_of_packet;
   assign w_owner_end = |(r_grant & i_end_of_packet);
   assign w_rr        = round_robin_select(RR_MAX'(w_head), r_last, REQUESTERS);
   assign w_winner    = w_rr[REQUESTERS-1:0];

   always_comb begin
      w_winner_idx = '0;
      for (int i = 0; i < RR_MAX; i++) begin
         if (w_rr[i]) w_winner_idx = RR_IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ARB_IDLE;
         r_grant <= '0;
         r_last  <= RR_IDX_W'(REQUESTERS - 1);
      end else begin
         r_state <= w_state_next;
         if (r_state == ARB_IDLE && |w_head) begin
            r_grant <= w_winner;
            r_last  <= w_winner_idx;
         end else if (r_state == ARB_LOCKED && w_owner_end) begin
            r_grant <= '0;
         end
      end
   end

   // While locked only the owner's tail matters, so a same-cycle tail+head from it releases first.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ARB_IDLE:   if (|w_head)     w_state_next = ARB_LOCKED;
         ARB_LOCKED: if (w_owner_end) w_state_next = ARB_IDLE;
      endcase
   end

   always_comb begin
      o_grant         = r_grant;
      o_owner_request = (r_state == ARB_LOCKED) && |(r_grant & i_request);
   end

`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
   localparam int WD_W = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;

   logic [WD_W-1:0] r_wd_count;
   logic            r_wd_error;
   logic            w_owner_free;

   assign w_owner_free = |(r_grant & i_free);

   // Counter saturates at the limit; the flag only reports, the lock stays in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wd_count <= '0;
         r_wd_error <= 1'b0;
      end else begin
         if (r_state == ARB_IDLE || w_owner_free) begin
            r_wd_count <= '0;
         end else if (r_wd_count != WD_W'(WATCHDOG_CYCLES - 1)) begin
            r_wd_count <= r_wd_count + WD_W'(1);
         end
         if (r_wd_count == WD_W'(WATCHDOG_CYCLES - 1)) r_wd_error <= 1'b1;
      end
   end

   assign o_watchdog_error = r_wd_error;
`endif

endmodule

// File: rtl/tnoc_output_port_arbiter.sv
// Output-port owner: per-VC packet locks (grant 1 cycle after head) plus combinational lowest-VC flit select.
// A VC drives the port only when its owner requests and i_vc_available is high. Build option TNOC_PORT_ARBITER_WATCHDOG_EN.
module tnoc_output_port_arbiter
   import tnoc_output_port_arbiter_pkg::*;
#(
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
   parameter int WATCHDOG_CYCLES = 1024,
`endif
   parameter int CHANNELS   = 2,
   parameter int REQUESTERS = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   tnoc_output_port_arbiter_if.slave  port_if
);

   localparam int N = CHANNELS * REQUESTERS;

   logic [N-1:0]        w_grant;
   logic [CHANNELS-1:0] w_owner_request;
   logic [CHANNELS-1:0] w_candidate;
   logic [CHANNELS-1:0] w_vc_grant;
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
   logic [CHANNELS-1:0] w_watchdog_error;
`endif

   for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
      tnoc_vc_lock_arbiter #(
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
         .WATCHDOG_CYCLES (WATCHDOG_CYCLES),
`endif
         .REQUESTERS      (REQUESTERS)
      ) u_lock (
         .clk               (clk),
         .rst               (rst),
         .i_request         (port_if.i_request[c*REQUESTERS +: REQUESTERS]),
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
         .i_free            (port_if.i_free[c*REQUESTERS +: REQUESTERS]),
         .o_watchdog_error  (w_watchdog_error[c]),
`endif
         .i_start_of_packet (port_if.i_start_of_packet[c*REQUESTERS +: REQUESTERS]),
         .i_end_of_packet   (port_if.i_end_of_packet[c*REQUESTERS +: REQUESTERS]),
         .o_grant           (w_grant[c*REQUESTERS +: REQUESTERS]),
         .o_owner_request   (w_owner_request[c])
      );
   end

   assign w_candidate = w_owner_request & port_if.i_vc_available;

   // Descending scan so the lowest candidate index is the one left standing.
   always_comb begin
      w_vc_grant = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (w_candidate[c]) begin
            w_vc_grant    = '0;
            w_vc_grant[c] = 1'b1;
         end
      end
   end

   assign port_if.o_grant    = w_grant;
   assign port_if.o_vc_grant = w_vc_grant;
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
   assign port_if.o_watchdog_error = |w_watchdog_error;
`endif

endmodule

// File: tb/tb_tnoc_output_port_arbiter.sv
// Directed bench for tnoc_output_port_arbiter (CHANNELS=2, REQUESTERS=5; WATCHDOG_CYCLES=8 in the watchdog build).
module tb_tnoc_output_port_arbiter;

   localparam int CH = 2;
   localparam int RQ = 5;
   localparam int N  = CH * RQ;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   tnoc_output_port_arbiter_if #(.CHANNELS(CH), .REQUESTERS(RQ)) pif ();

   tnoc_output_port_arbiter #(
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
      .WATCHDOG_CYCLES (8),
`endif
      .CHANNELS        (CH),
      .REQUESTERS      (RQ)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .port_if (pif)
   );

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      pif.i_request         = '0;
      pif.i_free            = '0;
      pif.i_start_of_packet = '0;
      pif.i_end_of_packet   = '0;
      pif.i_vc_available    = 2'b11;
   endtask

   function automatic logic [N-1:0] bit_of(input int c, input int r);
      logic [N-1:0] v;
      v = '0;
      v[c*RQ + r] = 1'b1;
      return v;
   endfunction

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      n_vec++;
      if (pif.o_grant !== '0) begin
         n_err++; $display("FAIL reset_grant got=%b want=%b", pif.o_grant, {N{1'b0}});
      end
      n_vec++;
      if (pif.o_vc_grant !== 2'b00) begin
         n_err++; $display("FAIL reset_vc_grant got=%b want=00", pif.o_vc_grant);
      end
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
      n_vec++;
      if (pif.o_watchdog_error !== 1'b0) begin
         n_err++; $display("FAIL reset_watchdog got=%b want=0", pif.o_watchdog_error);
      end
`endif
      rst = 1'b0;
   endtask

   // r0, r1, r4 keep heads up on VC0; 3-flit packets; expected order r0 r1 r4 r0.
   task automatic test_fairness();
      int           order [4];
      logic [N-1:0] heads;
      logic [N-1:0] w;
      order = '{0, 1, 4, 0};
      clear_inputs();
      heads = bit_of(0, 0) | bit_of(0, 1) | bit_of(0, 4);
      pif.i_request = heads;
      pif.i_start_of_packet = heads;
      #1;
      n_vec++;
      if (pif.o_grant !== '0) begin
         n_err++; $display("FAIL fair_pre got=%b want=%b", pif.o_grant, {N{1'b0}});
      end
      step();
      for (int k = 0; k < 4; k++) begin
         w = bit_of(0, order[k]);
         pif.i_free = w;
         #1;
         n_vec++;
         if (pif.o_grant !== w) begin
            n_err++; $display("FAIL fair_head pkt=%0d got=%b want=%b", k, pif.o_grant, w);
         end
         n_vec++;
         if (pif.o_vc_grant !== 2'b01) begin
            n_err++; $display("FAIL fair_vc pkt=%0d got=%b want=01", k, pif.o_vc_grant);
         end
         step();
         pif.i_start_of_packet = heads & ~w;
         #1;
         n_vec++;
         if (pif.o_grant !== w) begin
            n_err++; $display("FAIL fair_body pkt=%0d got=%b want=%b", k, pif.o_grant, w);
         end
         step();
         pif.i_end_of_packet = w;
         #1;
         n_vec++;
         if (pif.o_grant !== w) begin
            n_err++; $display("FAIL fair_tail pkt=%0d got=%b want=%b", k, pif.o_grant, w);
         end
         step();
         pif.i_end_of_packet = '0;
         pif.i_free = '0;
         pif.i_start_of_packet = (k == 3) ? '0 : heads;
         pif.i_request = (k == 3) ? '0 : heads;
         #1;
         n_vec++;
         if (pif.o_grant !== '0) begin
            n_err++; $display("FAIL fair_gap pkt=%0d got=%b want=%b", k, pif.o_grant, {N{1'b0}});
         end
         step();
      end
      clear_inputs();
   endtask

   task automatic test_single_grant();
      logic [N-1:0] h;
      clear_inputs();
      h = bit_of(0, 2);
      pif.i_request = h;
      pif.i_start_of_packet = h;
      #1;
      n_vec++;
      if (pif.o_grant !== '0) begin
         n_err++; $display("FAIL t1_latency got=%b want=%b", pif.o_grant, {N{1'b0}});
      end
      n_vec++;
      if (pif.o_vc_grant !== 2'b00) begin
         n_err++; $display("FAIL t1_vc_unlocked got=%b want=00", pif.o_vc_grant);
      end
      step();
      pif.i_free = h;
      #1;
      n_vec++;
      if (pif.o_grant !== h) begin
         n_err++; $display("FAIL t1_grant got=%b want=%b", pif.o_grant, h);
      end
      n_vec++;
      if (pif.o_vc_grant !== 2'b01) begin
         n_err++; $display("FAIL t1_vc_head got=%b want=01", pif.o_vc_grant);
      end
      step();
      pif.i_start_of_packet = '0;
      pif.i_end_of_packet = h;
      #1;
      n_vec++;
      if (pif.o_vc_grant !== 2'b01) begin
         n_err++; $display("FAIL t1_vc_tail got=%b want=01", pif.o_vc_grant);
      end
      step();
      clear_inputs();
      #1;
      n_vec++;
      if (pif.o_grant !== '0) begin
         n_err++; $display("FAIL t1_release got=%b want=%b", pif.o_grant, {N{1'b0}});
      end
   endtask

   task automatic test_vc_interleave();
      logic [N-1:0] heads;
      clear_inputs();
      heads = bit_of(0, 1) | bit_of(1, 3);
      pif.i_request = heads;
      pif.i_start_of_packet = heads;
      step();
      pif.i_start_of_packet = '0;
      pif.i_vc_available = 2'b10;
      #1;
      n_vec++;
      if (pif.o_grant !== heads) begin
         n_err++; $display("FAIL t3_locks got=%b want=%b", pif.o_grant, heads);
      end
      n_vec++;
      if (pif.o_vc_grant !== 2'b10) begin
         n_err++; $display("FAIL t3_vc_c0 got=%b want=10", pif.o_vc_grant);
      end
      step();
      #1;
      n_vec++;
      if (pif.o_vc_grant !== 2'b10) begin
         n_err++; $display("FAIL t3_vc_c1 got=%b want=10", pif.o_vc_grant);
      end
      step();
      pif.i_vc_available = 2'b11;
      #1;
      n_vec++;
      if (pif.o_vc_grant !== 2'b01) begin
         n_err++; $display("FAIL t3_vc_c2 got=%b want=01", pif.o_vc_grant);
      end
      pif.i_end_of_packet = heads;
      step();
      clear_inputs();
      #1;
      n_vec++;
      if (pif.o_grant !== '0) begin
         n_err++; $display("FAIL t3_release got=%b want=%b", pif.o_grant, {N{1'b0}});
      end
   endtask

   task automatic test_owner_bubble();
      logic [N-1:0] owner;
      logic [N-1:0] other;
      clear_inputs();
      owner = bit_of(0, 0);
      other = bit_of(0, 3);
      pif.i_request = owner;
      pif.i_start_of_packet = owner;
      step();
      pif.i_request = other;
      pif.i_start_of_packet = other;
      for (int k = 0; k < 4; k++) begin
         pif.i_end_of_packet = (k == 2) ? other : '0;
         #1;
         n_vec++;
         if (pif.o_grant !== owner) begin
            n_err++; $display("FAIL t4_bubble_grant cyc=%0d got=%b want=%b", k, pif.o_grant, owner);
         end
         n_vec++;
         if (pif.o_vc_grant !== 2'b00) begin
            n_err++; $display("FAIL t4_bubble_vc cyc=%0d got=%b want=00", k, pif.o_vc_grant);
         end
         step();
      end
      pif.i_end_of_packet = '0;
      pif.i_request = owner | other;
      #1;
      n_vec++;
      if (pif.o_vc_grant !== 2'b01) begin
         n_err++; $display("FAIL t4_resume_vc got=%b want=01", pif.o_vc_grant);
      end
      step();
      pif.i_end_of_packet = owner;
      pif.i_start_of_packet = owner | other;
      step();
      pif.i_end_of_packet = '0;
      #1;
      n_vec++;
      if (pif.o_grant !== '0) begin
         n_err++; $display("FAIL t4_end_first got=%b want=%b", pif.o_grant, {N{1'b0}});
      end
      step();
      #1;
      n_vec++;
      if (pif.o_grant !== other) begin
         n_err++; $display("FAIL t4_next_owner got=%b want=%b", pif.o_grant, other);
      end
      pif.i_end_of_packet = other;
      step();
      clear_inputs();
      #1;
      n_vec++;
      if (pif.o_grant !== '0) begin
         n_err++; $display("FAIL t4_release got=%b want=%b", pif.o_grant, {N{1'b0}});
      end
   endtask

   task automatic test_reset_mid_packet();
      logic [N-1:0] h;
      logic [N-1:0] heads;
      clear_inputs();
      h = bit_of(1, 1);
      pif.i_request = h;
      pif.i_start_of_packet = h;
      step();
      pif.i_start_of_packet = '0;
      pif.i_free = h;
      #1;
      n_vec++;
      if (pif.o_grant !== h) begin
         n_err++; $display("FAIL t5_lock got=%b want=%b", pif.o_grant, h);
      end
      step();
      rst = 1'b1;
      step();
      #1;
      n_vec++;
      if (pif.o_grant !== '0) begin
         n_err++; $display("FAIL t5_grant got=%b want=%b", pif.o_grant, {N{1'b0}});
      end
      n_vec++;
      if (pif.o_vc_grant !== 2'b00) begin
         n_err++; $display("FAIL t5_vc got=%b want=00", pif.o_vc_grant);
      end
      rst = 1'b0;
      clear_inputs();
      heads = bit_of(1, 0) | bit_of(1, 2);
      pif.i_request = heads;
      pif.i_start_of_packet = heads;
      step();
      #1;
      n_vec++;
      if (pif.o_grant !== bit_of(1, 0)) begin
         n_err++; $display("FAIL t5_rr_restart got=%b want=%b", pif.o_grant, bit_of(1, 0));
      end
      pif.i_end_of_packet = bit_of(1, 0);
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_single_flit();
      logic [N-1:0] h;
      clear_inputs();
      h = bit_of(1, 2);
      pif.i_request = h;
      pif.i_start_of_packet = h;
      #1;
      n_vec++;
      if (pif.o_grant !== '0) begin
         n_err++; $display("FAIL sf_pre got=%b want=%b", pif.o_grant, {N{1'b0}});
      end
      step();
      #1;
      n_vec++;
      if (pif.o_grant !== h) begin
         n_err++; $display("FAIL sf_grant got=%b want=%b", pif.o_grant, h);
      end
      pif.i_free = h;
      pif.i_end_of_packet = h;
      step();
      clear_inputs();
      #1;
      n_vec++;
      if (pif.o_grant !== '0) begin
         n_err++; $display("FAIL sf_release got=%b want=%b", pif.o_grant, {N{1'b0}});
      end
   endtask

`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
   task automatic test_watchdog();
      logic [N-1:0] h;
      clear_inputs();
      pif.i_vc_available = 2'b00;
      h = bit_of(0, 1);
      pif.i_request = h;
      pif.i_start_of_packet = h;
      step();
      pif.i_start_of_packet = '0;
      #1;
      n_vec++;
      if (pif.o_grant !== h) begin
         n_err++; $display("FAIL wd_lock got=%b want=%b", pif.o_grant, h);
      end
      for (int k = 1; k <= 8; k++) begin
         step();
         n_vec++;
         if (pif.o_watchdog_error !== (k == 8)) begin
            n_err++; $display("FAIL wd_rise cyc=%0d got=%b want=%b", k, pif.o_watchdog_error, (k == 8));
         end
      end
      step();
      step();
      n_vec++;
      if (pif.o_grant !== h) begin
         n_err++; $display("FAIL wd_lock_kept got=%b want=%b", pif.o_grant, h);
      end
      pif.i_free = h;
      pif.i_end_of_packet = h;
      step();
      clear_inputs();
      #1;
      n_vec++;
      if (pif.o_watchdog_error !== 1'b1) begin
         n_err++; $display("FAIL wd_sticky got=%b want=1", pif.o_watchdog_error);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_vec++;
      if (pif.o_watchdog_error !== 1'b0) begin
         n_err++; $display("FAIL wd_reset got=%b want=0", pif.o_watchdog_error);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_fairness();
      test_single_grant();
      test_vc_interleave();
      test_owner_bubble();
      test_reset_mid_packet();
      test_single_flit();
`ifdef TNOC_PORT_ARBITER_WATCHDOG_EN
      test_watchdog();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
